bfp_frame_packer: RTL and testbench
===================================

Name: bfp_frame_packer

Overview:
- Downstream neighbour of the block-precision normalizer.
- Consumes the normalizer's stream of BLOCK_SIZE complex_mant_t mantissas plus the shared block exponent.
- Emits a self-describing framed stream: one header beat carrying exponent and sequence number, then BLOCK_SIZE payload beats with SOF/EOF markers.
- Buffers payload in a small FIFO so upstream is not stalled while the header goes out.

Parameters:
BLOCK_SIZE, qpu_pkg::BLOCK_SIZE, payload beats per frame (power of two, >=2)
FIFO_DEPTH, 4, payload buffer entries (power of two, >=2)
SEQ_WIDTH, 8, frame sequence counter width; EXP_WIDTH+SEQ_WIDTH <= 2*MANT_WIDTH

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
valid_in  in  1  upstream sample valid
ready_in  out  1  upstream ready
data_in  in  complex_mant_t  normalized mantissa pair
exp_in  in  exp_t  block exponent; stable for the whole block
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  2*MANT_WIDTH  header or payload beat
out_sof  out  1  high on header beat
out_eof  out  1  high on last payload beat
frame_done  out  1  one-cycle pulse after EOF handshake
exp_err  out  1  sticky: exp_in changed mid-block

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=S_IDLE, FIFO empty, counters 0, frame_seq=0, ready_in=0 (comb from reset state is allowed to be 1 in S_IDLE once rst deasserted), out_valid=0, out_sof=0, out_eof=0, frame_done=0, exp_err=0.
- Input side:
  - ready_in = !fifo_full && (in_cnt < BLOCK_SIZE).
  - Accept = valid_in && ready_in; each accept pushes data_in and increments in_cnt.
  - Once BLOCK_SIZE samples are accepted, ready_in stays low until frame_done, so blocks never mix exponents.
  - First accept of a block (in_cnt==0) latches exp_in into exp_q.
  - Later accepts with exp_in != exp_q set exp_err (sticky until reset; data still passes).
- Output FSM:
  - S_IDLE: out_valid=0. On first accept go to S_HDR next cycle.
  - S_HDR: out_valid=1, out_sof=1, out_data = {zero pad, frame_seq, exp_q}, exponent in LSBs. Hold stable until out_ready. On handshake go to S_PAY.
  - S_PAY: out_valid = !fifo_empty; out_data = FIFO head {real, imag}, real in MSBs. Each handshake pops the FIFO and increments out_cnt. out_eof=1 when out_cnt==BLOCK_SIZE-1. On the EOF handshake: frame_done pulses next cycle, frame_seq increments (wraps modulo 2^SEQ_WIDTH), in_cnt and out_cnt clear, state returns to S_IDLE.
- Latency:
  - First accept at cycle N gives header valid at N+1.
  - With out_ready held high, the first payload beat follows at N+2, then one beat per cycle.
- Stability rule: while out_valid && !out_ready, out_data, out_sof and out_eof must not change.
- Simultaneous events:
  - FIFO push and pop in the same cycle keep the count unchanged, and are legal when full because the pop frees the entry.
  - ready_in is not allowed to combinationally depend on out_ready (no comb path in to out).
  - The first accept of the next block is permitted in the cycle after frame_done.
- Reset mid-frame: all state is discarded immediately, with no partial frame emitted after reset.
- in_cnt and out_cnt are $clog2(BLOCK_SIZE)+1 bits wide, and counters do not wrap within a frame.

Decomposition:
- qpu_pkg holds:
  - complex_mant_t, mant_t, exp_t, MANT_WIDTH, EXP_WIDTH, BLOCK_SIZE.
  - New localparam FRAME_WIDTH = 2*MANT_WIDTH.
  - New typedef frame_hdr_t (seq, exp fields).
- One sub-module, sync_fifo:
  - Parameters WIDTH, DEPTH; ports push, pop, wdata, rdata (first-word-fall-through head), full, empty.
  - Uses the same async reset.

Test Plan:
- BLOCK_SIZE=8, exp_in=5, 8 samples real=i, imag=-i, out_ready=1 -> header {seq=0, exp=5} one cycle after first accept, then 8 payload beats in order, eof on the 8th, frame_done one cycle later.
- Same block with out_ready toggling 1,0,0,1 repeatedly -> no beat lost or duplicated; out_data stable during every stall; FIFO fills, ready_in drops at 4 entries and recovers on pop.
- Two back-to-back blocks (exp 5 then 12) -> headers seq=0/exp=5 and seq=1/exp=12; no sample of block 2 accepted before frame 1's frame_done.
- exp_in changes from 5 to 6 at sample 3 -> exp_err rises the cycle after that accept and stays high; header still shows exp=5.
- 256 frames -> frame_seq wraps from 255 to 0 on the 257th header.
- Assert rst during payload beat 4 -> all outputs 0 immediately; next block starts at seq=0 with a fresh header.

Source files
------------

// File: rtl/qpu_pkg.sv
// Shared mantissa/exponent types for the block-floating-point datapath.
// Framing adds FRAME_WIDTH and the header layout used by the frame packer.
package qpu_pkg;
   localparam int MANT_WIDTH    = 16;
   localparam int EXP_WIDTH     = 8;
   localparam int BLOCK_SIZE    = 8;
   localparam int FRAME_WIDTH   = 2*MANT_WIDTH;
   localparam int HDR_SEQ_WIDTH = 8;

   typedef logic signed [MANT_WIDTH-1:0] mant_t;
   typedef logic [EXP_WIDTH-1:0]         exp_t;

   typedef struct packed {
      mant_t re;
      mant_t im;
   } complex_mant_t;

   // Header beat payload, exponent in the LSBs, zero padded up to FRAME_WIDTH.
   typedef struct packed {
      logic [HDR_SEQ_WIDTH-1:0] seq;
      exp_t                     exp;
   } frame_hdr_t;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} pack_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Small FWFT FIFO: rdata shows the head combinationally, push and pop are registered.
// Latency: one cycle push-to-head. Backpressure: push while full is dropped unless a pop frees the slot.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/bfp_frame_packer.sv
// Frames normalized mantissa blocks as one header beat {seq, exp} followed by BLOCK_SIZE payload beats.
// Latency: header one cycle after first accept; backpressure: FIFO absorbs payload, ready_in never sees out_ready.
module bfp_frame_packer
   import qpu_pkg::*;
#(
   parameter int BLOCK_SIZE = qpu_pkg::BLOCK_SIZE,
   parameter int FIFO_DEPTH = 4,
   parameter int SEQ_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_in,
   output logic                   ready_in,
   input  complex_mant_t          data_in,
   input  exp_t                   exp_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FRAME_WIDTH-1:0] out_data,
   output logic                   out_sof,
   output logic                   out_eof,
   output logic                   frame_done,
   output logic                   exp_err
);
   localparam int CW = $clog2(BLOCK_SIZE) + 1;
   typedef logic [CW-1:0] cnt_t;

   pack_state_t            state;
   cnt_t                   in_cnt;
   cnt_t                   out_cnt;
   exp_t                   exp_q;
   logic [SEQ_WIDTH-1:0]   frame_seq;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [FRAME_WIDTH-1:0] fifo_head;
   logic                   accept;
   logic                   pay_hs;

   // in_cnt saturates at BLOCK_SIZE until the EOF handshake, so blocks never interleave.
   assign ready_in = !rst && !fifo_full && (in_cnt < cnt_t'(BLOCK_SIZE));
   assign accept   = valid_in && ready_in;

   assign out_valid = (state == S_HDR) || ((state == S_PAY) && !fifo_empty);
   assign out_sof   = (state == S_HDR);
   assign out_eof   = (state == S_PAY) && !fifo_empty && (out_cnt == cnt_t'(BLOCK_SIZE-1));
   assign out_data  = (state == S_PAY) ? fifo_head : FRAME_WIDTH'({frame_seq, exp_q});
   assign pay_hs    = (state == S_PAY) && !fifo_empty && out_ready;

   sync_fifo #(
      .WIDTH (FRAME_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pay_hs),
      .wdata (data_in),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         in_cnt     <= '0;
         out_cnt    <= '0;
         exp_q      <= '0;
         frame_seq  <= '0;
         frame_done <= 1'b0;
         exp_err    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (accept) begin
            in_cnt <= in_cnt + cnt_t'(1);
            if (in_cnt == '0)
               exp_q <= exp_in;
            else if (exp_in != exp_q)
               exp_err <= 1'b1;
         end
         case (state)
            S_IDLE: if (accept) state <= S_HDR;
            S_HDR:  if (out_ready) state <= S_PAY;
            S_PAY: begin
               if (pay_hs) begin
                  if (out_eof) begin
                     out_cnt    <= '0;
                     in_cnt     <= '0;
                     frame_seq  <= frame_seq + SEQ_WIDTH'(1);
                     frame_done <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     out_cnt <= out_cnt + cnt_t'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bfp_frame_packer.sv
// Scoreboard bench for bfp_frame_packer: expected beats are queued at accept time and popped on output handshakes.
module tb_bfp_frame_packer;
   import qpu_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [FRAME_WIDTH-1:0] data;
      logic                   sof;
      logic                   eof;
   } beat_t;

   logic                   clk;
   logic                   rst;
   logic                   valid_in;
   logic                   ready_in;
   complex_mant_t          data_in;
   exp_t                   exp_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [FRAME_WIDTH-1:0] out_data;
   logic                   out_sof;
   logic                   out_eof;
   logic                   frame_done;
   logic                   exp_err;

   bfp_frame_packer #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .FIFO_DEPTH (DEPTH),
      .SEQ_WIDTH  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .ready_in   (ready_in),
      .data_in    (data_in),
      .exp_in     (exp_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sof    (out_sof),
      .out_eof    (out_eof),
      .frame_done (frame_done),
      .exp_err    (exp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   beat_t sb[$];
   int hs_cyc[$];
   int cyc = 0;
   int pushes = 0;
   int pops_done = 0;
   int eof_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int blocks_sent = 0;
   logic [7:0] seq_model = 8'd0;
   logic err_model = 1'b0;
   logic rec_en = 1'b0;
   logic toggle_en = 1'b0;
   int ph = 0;
   logic saw_full = 1'b0;
   logic stall_prev = 1'b0;
   logic [FRAME_WIDTH-1:0] prev_data;
   logic prev_sof;
   logic prev_eof;

   // One clock of monitoring: observe at negedge, return at posedge+1 with inputs free to change.
   task automatic tick();
      beat_t eb;
      logic [3:0] pat;
      @(negedge clk);
      cyc++;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_sof !== prev_sof || out_eof !== prev_eof) begin
               errors++;
               $display("FAIL stall_hold: valid=%b data=%h sof=%b eof=%b, required valid=1 data=%h sof=%b eof=%b",
                        out_valid, out_data, out_sof, out_eof, prev_data, prev_sof, prev_eof);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: data=%h sof=%b eof=%b, required no beat", out_data, out_sof, out_eof);
            end else begin
               eb = sb.pop_front();
               if (out_data !== eb.data || out_sof !== eb.sof || out_eof !== eb.eof) begin
                  errors++;
                  $display("FAIL beat: data=%h sof=%b eof=%b, required data=%h sof=%b eof=%b",
                           out_data, out_sof, out_eof, eb.data, eb.sof, eb.eof);
               end
            end
            if (!out_sof) pops_done++;
            if (out_eof) eof_cnt++;
            if (rec_en) hs_cyc.push_back(cyc);
         end
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         prev_sof   = out_sof;
         prev_eof   = out_eof;
      end
      @(posedge clk);
      #1;
      if (toggle_en) begin
         pat = 4'b1001;
         out_ready = pat[3 - (ph % 4)];
         ph++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid_in = 1'b0;
      out_ready = 1'b0;
      toggle_en = 1'b0;
      sb.delete();
      pushes = 0; pops_done = 0; eof_cnt = 0; done_cnt = 0; blocks_sent = 0;
      seq_model = 8'd0;
      err_model = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic send_block(input logic [7:0] e, input int chg, input logic [7:0] e2);
      int n = 0;
      int guard = 0;
      logic [7:0] ev;
      logic [7:0] blk_exp = e;
      logic exp_rdy;
      logic first;
      logic [15:0] rv;
      logic [15:0] iv;
      beat_t b;
      while (n < BLOCK_SIZE && guard < 2000) begin
         exp_rdy = !rst && ((pushes - pops_done) < DEPTH) && (eof_cnt >= blocks_sent);
         checks++;
         if (ready_in !== exp_rdy) begin
            errors++;
            $display("FAIL ready_in: got %b, required %b (occ=%0d n=%0d)", ready_in, exp_rdy, pushes - pops_done, n);
         end
         checks++;
         if (exp_err !== err_model) begin
            errors++;
            $display("FAIL exp_err: got %b, required %b (n=%0d)", exp_err, err_model, n);
         end
         if (n > 0 && ready_in !== 1'b1) saw_full = 1'b1;
         ev = (chg >= 0 && n >= chg) ? e2 : e;
         rv = 16'(n);
         iv = 16'(-n);
         valid_in = 1'b1;
         data_in.re = rv;
         data_in.im = iv;
         exp_in = ev;
         first = 1'b0;
         if (ready_in) begin
            if (n == 0) begin
               checks++;
               if ((done_cnt + (frame_done ? 1 : 0)) < blocks_sent) begin
                  errors++;
                  $display("FAIL block_order: frames done %0d, required %0d before next block", done_cnt, blocks_sent);
               end
               blk_exp = ev;
               b.data = {16'h0000, seq_model, ev};
               b.sof = 1'b1;
               b.eof = 1'b0;
               sb.push_back(b);
               first = 1'b1;
            end else if (ev != blk_exp) begin
               err_model = 1'b1;
            end
            b.data = {rv, iv};
            b.sof = 1'b0;
            b.eof = (n == BLOCK_SIZE-1);
            sb.push_back(b);
            pushes++;
            n++;
         end
         tick();
         if (first) begin
            checks++;
            if (out_valid !== 1'b1 || out_sof !== 1'b1) begin
               errors++;
               $display("FAIL hdr_latency: valid=%b sof=%b, required valid=1 sof=1", out_valid, out_sof);
            end
         end
         guard++;
      end
      valid_in = 1'b0;
      if (n < BLOCK_SIZE) begin
         errors++;
         checks++;
         $display("FAIL send_timeout: accepted %0d, required %0d", n, BLOCK_SIZE);
      end
      blocks_sent++;
      seq_model = seq_model + 8'd1;
   endtask

   task automatic wait_drain();
      int guard = 0;
      while ((sb.size() != 0 || done_cnt < blocks_sent) && guard < 3000) begin
         tick();
         guard++;
      end
      checks++;
      if (sb.size() != 0 || done_cnt < blocks_sent) begin
         errors++;
         $display("FAIL drain_timeout: pending=%0d done=%0d, required pending=0 done=%0d", sb.size(), done_cnt, blocks_sent);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if ({out_valid, out_sof, out_eof, frame_done, exp_err, ready_in} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: valid/sof/eof/done/err/rdy=%b, required 000000",
                  {out_valid, out_sof, out_eof, frame_done, exp_err, ready_in});
      end
      rst = 1'b0;
      tick();
      checks++;
      if (ready_in !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: ready_in=%b out_valid=%b, required 1 and 0", ready_in, out_valid);
      end
   endtask

   task automatic test_single_frame();
      do_reset();
      out_ready = 1'b1;
      hs_cyc.delete();
      rec_en = 1'b1;
      send_block(8'd5, -1, 8'd0);
      wait_drain();
      rec_en = 1'b0;
      checks++;
      if (hs_cyc.size() != BLOCK_SIZE + 1) begin
         errors++;
         $display("FAIL beat_count: got %0d, required %0d", hs_cyc.size(), BLOCK_SIZE + 1);
      end else begin
         for (int k = 1; k <= BLOCK_SIZE; k++) begin
            checks++;
            if (hs_cyc[k] != hs_cyc[0] + k) begin
               errors++;
               $display("FAIL beat_timing: beat %0d at cycle %0d, required %0d", k, hs_cyc[k], hs_cyc[0] + k);
            end
         end
         checks++;
         if (done_cyc != hs_cyc[BLOCK_SIZE] + 1) begin
            errors++;
            $display("FAIL done_timing: frame_done at %0d, required %0d", done_cyc, hs_cyc[BLOCK_SIZE] + 1);
         end
      end
   endtask

   task automatic test_backpressure();
      saw_full = 1'b0;
      ph = 0;
      toggle_en = 1'b1;
      send_block(8'd5, -1, 8'd0);
      wait_drain();
      toggle_en = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (saw_full !== 1'b1) begin
         errors++;
         $display("FAIL fifo_fill: ready_in never dropped mid-block, required a drop at %0d entries", DEPTH);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b1;
      send_block(8'd5, -1, 8'd0);
      send_block(8'd12, -1, 8'd0);
      wait_drain();
   endtask

   task automatic test_exp_err();
      do_reset();
      out_ready = 1'b1;
      send_block(8'd5, 3, 8'd6);
      wait_drain();
      repeat (2) tick();
      checks++;
      if (exp_err !== 1'b1) begin
         errors++;
         $display("FAIL exp_err_sticky: got %b, required 1", exp_err);
      end
   endtask

   task automatic test_seq_wrap();
      do_reset();
      out_ready = 1'b1;
      for (int f = 0; f < 257; f++) send_block(8'(f % 16), -1, 8'd0);
      wait_drain();
   endtask

   task automatic test_reset_mid_frame();
      beat_t b;
      logic [15:0] rv;
      logic [15:0] iv;
      do_reset();
      out_ready = 1'b1;
      valid_in = 1'b1;
      exp_in = 8'd9;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (ready_in !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready: got %b at sample %0d, required 1", ready_in, k);
         end
         rv = 16'(k);
         iv = 16'(-k);
         data_in.re = rv;
         data_in.im = iv;
         if (k == 0) begin
            b.data = {16'h0000, seq_model, 8'd9};
            b.sof = 1'b1;
            b.eof = 1'b0;
            sb.push_back(b);
         end
         b.data = {rv, iv};
         b.sof = 1'b0;
         b.eof = 1'b0;
         sb.push_back(b);
         pushes++;
         tick();
      end
      checks++;
      if (out_valid !== 1'b1 || out_sof !== 1'b0 || pops_done != 3) begin
         errors++;
         $display("FAIL mid_position: valid=%b sof=%b pops=%0d, required valid=1 sof=0 pops=3", out_valid, out_sof, pops_done);
      end
      valid_in = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_sof, out_eof, frame_done, exp_err, ready_in} !== 6'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: valid/sof/eof/done/err/rdy=%b, required 000000",
                  {out_valid, out_sof, out_eof, frame_done, exp_err, ready_in});
      end
      do_reset();
      out_ready = 1'b1;
      repeat (3) tick();
      send_block(8'd3, -1, 8'd0);
      wait_drain();
   endtask

   initial begin
      rst = 1'b1;
      valid_in = 1'b0;
      out_ready = 1'b0;
      data_in = '0;
      exp_in = '0;
      test_reset();
      test_single_frame();
      test_backpressure();
      test_back_to_back();
      test_exp_err();
      test_seq_wrap();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
